serial_to_parallel_idle: RTL and testbench

- Receive-side counterpart of the parallel-to-serial IDLE transmitter; sits at the lane input of the PCIe physical-layer receive path.
- Deserialises an MSB-first bit stream into bytes.
- Acquires byte alignment by hunting for the COM/IDLE symbol 0xBC, then declares the lane active after BC_COUNT consecutive aligned COM symbols.
- Once active, delivers data bytes with a valid flag and flags IDLE bytes separately.

---
 rtl/pcie_phy_pkg.sv | 17 +
 rtl/s2p_shift8.sv | 29 ++
 rtl/serial_to_parallel_idle.sv | 118 +++++++++++
 tb/tb_serial_to_parallel_idle.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY lane definitions: the COM/IDLE symbol and the lane alignment states.
// Used by both the IDLE transmitter and the serial-to-parallel receiver.
package pcie_phy_pkg;

    localparam logic [7:0] COM_SYM = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } phy_state_t;

    function automatic logic is_com(input logic [7:0] sym);
        return sym == COM_SYM;
    endfunction

endpackage

// File: rtl/s2p_shift8.sv
// MSB-first serial shift window with a 3-bit bit counter; cand is the byte completed by this edge.
// Combinational cand/boundary; no backpressure (one bit per clock, always accepted).
module s2p_shift8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    input  logic       realign,
    output logic [7:0] cand,
    output logic       boundary
);

    // Only the 7 most recent bits are needed: the 8th comes straight from data_in.
    logic [6:0] hist;
    logic [2:0] bit_cnt;

    assign cand     = {hist, data_in};
    assign boundary = (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist    <= '0;
            bit_cnt <= '0;
        end else begin
            hist    <= cand[6:0];
            bit_cnt <= realign ? 3'd0 : bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/serial_to_parallel_idle.sv
// PCIe lane receiver: hunts for COM (0xBC), locks after BC_COUNT aligned COMs, then delivers bytes.
// Outputs update on the edge sampling a byte's last bit; no backpressure. Optional idle_count: S2P_IDLE_CNT_EN.
module serial_to_parallel_idle
    import pcie_phy_pkg::*;
#(
    parameter int unsigned BC_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       idle_out,
    output logic       byte_strobe,
`ifdef S2P_IDLE_CNT_EN
    output logic [7:0] idle_count,
`endif
    output logic       active
);

    localparam logic [3:0] BC_TGT = 4'(BC_COUNT);

    phy_state_t state, state_nxt;
    logic [3:0] bc_cnt, bc_nxt;
    logic [7:0] cand;
    logic       boundary;
    logic       realign;
    logic [7:0] data_nxt;
    logic       valid_nxt, idle_nxt, strobe_nxt;
`ifdef S2P_IDLE_CNT_EN
    logic [7:0] idle_cnt_nxt;
`endif

    s2p_shift8 u_shift (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .realign  (realign),
        .cand     (cand),
        .boundary (boundary)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HUNT;
            bc_cnt      <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            idle_out    <= 1'b0;
            byte_strobe <= 1'b0;
`ifdef S2P_IDLE_CNT_EN
            idle_count  <= '0;
`endif
        end else begin
            state       <= state_nxt;
            bc_cnt      <= bc_nxt;
            data_out    <= data_nxt;
            valid_out   <= valid_nxt;
            idle_out    <= idle_nxt;
            byte_strobe <= strobe_nxt;
`ifdef S2P_IDLE_CNT_EN
            idle_count  <= idle_cnt_nxt;
`endif
        end
    end

    // HUNT slides over every bit position; LOCK only trusts bytes on the fixed boundary.
    always_comb begin
        state_nxt = state;
        bc_nxt    = bc_cnt;
        realign   = 1'b0;
        case (state)
            HUNT: begin
                if (is_com(cand)) begin
                    realign   = 1'b1;
                    bc_nxt    = 4'd1;
                    state_nxt = (BC_TGT == 4'd1) ? ACTIVE : LOCK;
                end
            end
            LOCK: begin
                if (boundary) begin
                    if (is_com(cand)) begin
                        bc_nxt = bc_cnt + 4'd1;
                        if (bc_cnt + 4'd1 == BC_TGT) state_nxt = ACTIVE;
                    end else begin
                        bc_nxt    = 4'd0;
                        state_nxt = HUNT;
                    end
                end
            end
            ACTIVE:  state_nxt = ACTIVE;
            default: state_nxt = HUNT;
        endcase
    end

    // Gated on the current state, so the COM that completes lock is never reported.
    always_comb begin
        data_nxt   = data_out;
        valid_nxt  = valid_out;
        idle_nxt   = idle_out;
        strobe_nxt = 1'b0;
`ifdef S2P_IDLE_CNT_EN
        idle_cnt_nxt = idle_count;
`endif
        if (state == ACTIVE && boundary) begin
            data_nxt   = cand;
            strobe_nxt = 1'b1;
            idle_nxt   = is_com(cand);
            valid_nxt  = !is_com(cand);
`ifdef S2P_IDLE_CNT_EN
            if (is_com(cand) && idle_count != 8'hFF) idle_cnt_nxt = idle_count + 8'd1;
`endif
        end
    end

    assign active = (state == ACTIVE);

endmodule

// File: tb/tb_serial_to_parallel_idle.sv
// Directed bench for serial_to_parallel_idle: alignment, lock, data/IDLE delivery and reset.
module tb_serial_to_parallel_idle;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, idle_out, byte_strobe, active;
`ifdef S2P_IDLE_CNT_EN
    logic [7:0] idle_count;
`endif

    int checks = 0;
    int errors = 0;

    serial_to_parallel_idle #(.BC_COUNT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .idle_out    (idle_out),
        .byte_strobe (byte_strobe),
`ifdef S2P_IDLE_CNT_EN
        .idle_count  (idle_count),
`endif
        .active      (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    // Sends the top n bits of b, MSB first.
    task automatic send_msb(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_msb(b, 8);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        data_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // {data_out, valid, idle, strobe, active}
    function automatic logic [11:0] outs();
        return {data_out, valid_out, idle_out, byte_strobe, active};
    endfunction

    initial begin
        // Test 1: clean 4x COM then 0xA5
        do_reset();
        check("reset_outputs", 32'(outs()), 32'h0);
        repeat (3) send_byte(8'hBC);
        send_msb(8'hBC, 7);
        check("t1_active_before_32", 32'(active), 32'h0);
        send_bit(1'b0);
        check("t1_active_at_32", 32'(active), 32'h1);
        check("t1_no_strobe_on_lock_com", 32'(byte_strobe), 32'h0);
        send_msb(8'hA5, 7);
        check("t1_no_strobe_mid_byte", 32'(byte_strobe), 32'h0);
        send_bit(1'b1);
        check("t1_a5_outs", 32'(outs()), 32'({8'hA5, 1'b1, 1'b0, 1'b1, 1'b1}));
        send_bit(1'b0);
        check("t1_strobe_one_cycle", 32'(byte_strobe), 32'h0);
        check("t1_data_holds", 32'(data_out), 32'hA5);

        // Test 2: 3 junk bits then alignment
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (3) send_byte(8'hBC);
        check("t2_not_active_3com", 32'(active), 32'h0);
        send_byte(8'hBC);
        check("t2_active", 32'(active), 32'h1);
        send_byte(8'h3C);
        check("t2_3c_outs", 32'(outs()), 32'({8'h3C, 1'b1, 1'b0, 1'b1, 1'b1}));

        // Test 3: lock broken by 0x00, then full relock
        do_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h00);
        check("t3_inactive_after_00", 32'(active), 32'h0);
        repeat (3) send_byte(8'hBC);
        check("t3_inactive_3com", 32'(active), 32'h0);
        send_byte(8'hBC);
        check("t3_active_4com", 32'(active), 32'h1);
        check("t3_nothing_reported", 32'(outs()), 32'({8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));

        // Test 4: IDLE then data while active
        send_byte(8'hBC);
        check("t4_idle_outs", 32'(outs()), 32'({8'hBC, 1'b0, 1'b1, 1'b1, 1'b1}));
        send_byte(8'h55);
        check("t4_data_outs", 32'(outs()), 32'({8'h55, 1'b1, 1'b0, 1'b1, 1'b1}));

        // Test 5: mid-byte async reset while active
        send_msb(8'h12, 4);
        reset = 1'b0;
        #2;
        check("t5_async_clear", 32'(outs()), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) send_byte(8'hBC);
        check("t5_inactive_3com", 32'(active), 32'h0);
        send_byte(8'hBC);
        check("t5_relock", 32'(active), 32'h1);

`ifdef S2P_IDLE_CNT_EN
        // Test 6: idle_count saturates
        check("t6_count_start", 32'(idle_count), 32'h0);
        repeat (300) send_byte(8'hBC);
        check("t6_count_sat", 32'(idle_count), 32'hFF);
        send_byte(8'hBC);
        check("t6_count_hold", 32'(idle_count), 32'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
